// File: rtl/os_pkg.sv
// rtl/os_pkg.sv - shared sizing for the output-stationary array and its collectors
// Purpose: one place for the row width and partial-sum width, so the mac_tile
//          wrappers and os_psum_collector are always sized the same way.
// Ports:   none (package).
package os_pkg;

  localparam int PSUM_BW = 16;
  localparam int COL     = 8;
  localparam int IDX_BW  = 3;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - rotating-priority arbiter over the collector hold bank
// Purpose: picks the first requesting entry starting at ptr_i and wrapping
//          around, so every tile gets a turn.
// Ports:   req_i   - one request bit per entry
//          ptr_i   - entry with highest priority this cycle
//          grant_o - one-hot grant (all zero when nothing requests)
//          sel_o   - binary index of the granted entry
//          any_o   - at least one request present
module rr_arbiter
  import os_pkg::*;
#(
  parameter int col    = COL,
  parameter int idx_bw = IDX_BW
) (
  input  logic [col-1:0]    req_i,
  input  logic [idx_bw-1:0] ptr_i,
  output logic [col-1:0]    grant_o,
  output logic [idx_bw-1:0] sel_o,
  output logic              any_o
);

  int                j;
  logic [idx_bw-1:0] cand;

  // Walk ptr, ptr+1, ... modulo col; the first hit wins.
  always_comb begin
    grant_o = '0;
    sel_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    cand    = '0;
    for (int k = 0; k < col; k++) begin
      j = int'(ptr_i) + k;
      if (j >= col) begin
        j = j - col;
      end
      cand = idx_bw'(j);
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        grant_o[cand] = 1'b1;
        sel_o         = cand;
      end
    end
  end

endmodule

// File: rtl/os_psum_collector.sv
// rtl/os_psum_collector.sv - drains finished OS partial sums from a row of mac_tiles
// Purpose: edge-detects each tile's os_ready, buffers one result per tile and
//          serializes them round-robin onto a valid/ready stream, optionally
//          clamping negative results to zero.
// Ports:   clk, reset            - clock, synchronous active-high reset
//          os_ready, os_output   - per-tile done flag and packed per-tile result
//          relu_en               - clamp negative results when loading the output stage
//          out_valid/out_ready   - output handshake
//          out_data, out_idx     - result and the tile it came from
//          overflow              - sticky per-tile "result arrived while previous still held"
//          round_done            - one-cycle pulse after every col accepted results
//          busy                  - something is held or waiting at the output
module os_psum_collector
  import os_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int idx_bw  = IDX_BW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         os_ready,
  input  logic [col*psum_bw-1:0] os_output,
  input  logic                   relu_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [psum_bw-1:0]     out_data,
  output logic [idx_bw-1:0]      out_idx,
  output logic [col-1:0]         overflow,
  output logic                   round_done,
  output logic                   busy
);

  localparam logic [idx_bw-1:0] LAST_IDX = idx_bw'(col - 1);

  logic [col-1:0]     os_ready_q;
  logic [col-1:0]     rise;
  logic [col-1:0]     hold_valid_q, hold_valid_d;
  logic [psum_bw-1:0] hold_data_q [col];
  logic [psum_bw-1:0] hold_data_d [col];
  logic [col-1:0]     overflow_q, overflow_d;
  logic               out_valid_q, out_valid_d;
  logic [psum_bw-1:0] out_data_q, out_data_d;
  logic [idx_bw-1:0]  out_idx_q, out_idx_d;
  logic [idx_bw-1:0]  ptr_q, ptr_d;
  logic [idx_bw-1:0]  acc_cnt_q, acc_cnt_d;
  logic               round_done_q, round_done_d;

  logic [col-1:0]     grant;
  logic [idx_bw-1:0]  sel;
  logic               any_req;
  logic               load;
  logic               accept;
  logic [psum_bw-1:0] sel_data;

  rr_arbiter #(
    .col    (col),
    .idx_bw (idx_bw)
  ) u_arb (
    .req_i   (hold_valid_q),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .sel_o   (sel),
    .any_o   (any_req)
  );

  // A level that stays high captures only once.
  assign rise     = os_ready & ~os_ready_q;
  assign accept   = out_valid_q & out_ready;
  assign load     = (~out_valid_q | out_ready) & any_req;
  assign sel_data = hold_data_q[sel];

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    overflow_d   = overflow_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_idx_d    = out_idx_q;
    ptr_d        = ptr_q;
    acc_cnt_d    = acc_cnt_q;
    round_done_d = 1'b0;

    if (load) begin
      hold_valid_d = hold_valid_q & ~grant;
      out_valid_d  = 1'b1;
      // ReLU is applied here rather than at capture, so relu_en is sampled at load.
      out_data_d   = (relu_en && sel_data[psum_bw-1]) ? '0 : sel_data;
      out_idx_d    = sel;
      ptr_d        = (sel == LAST_IDX) ? '0 : sel + idx_bw'(1);
    end else if (accept) begin
      out_valid_d = 1'b0;
    end

    // An entry leaving for the output stage on this edge frees its slot for a
    // result arriving on the same edge, which is not an overflow.
    for (int i = 0; i < col; i++) begin
      if (rise[i]) begin
        if (!hold_valid_q[i] || (load && grant[i])) begin
          hold_valid_d[i] = 1'b1;
          hold_data_d[i]  = os_output[i*psum_bw +: psum_bw];
        end else begin
          overflow_d[i] = 1'b1;
        end
      end
    end

    if (accept) begin
      if (acc_cnt_q == LAST_IDX) begin
        acc_cnt_d    = '0;
        round_done_d = 1'b1;
      end else begin
        acc_cnt_d = acc_cnt_q + idx_bw'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      os_ready_q   <= '0;
      hold_valid_q <= '0;
      hold_data_q  <= '{default: '0};
      overflow_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      ptr_q        <= '0;
      acc_cnt_q    <= '0;
      round_done_q <= 1'b0;
    end else begin
      os_ready_q   <= os_ready;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      overflow_q   <= overflow_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_idx_q    <= out_idx_d;
      ptr_q        <= ptr_d;
      acc_cnt_q    <= acc_cnt_d;
      round_done_q <= round_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_idx    = out_idx_q;
  assign overflow   = overflow_q;
  assign round_done = round_done_q;
  assign busy       = (|hold_valid_q) | out_valid_q;

endmodule

// File: tb/tb_os_psum_collector.sv
// tb/tb_os_psum_collector.sv - self-checking bench for os_psum_collector
module tb_os_psum_collector;
  import os_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic [COL-1:0]         os_ready;
  logic [COL*PSUM_BW-1:0] os_output;
  logic                   relu_en;
  logic                   out_valid;
  logic                   out_ready;
  logic [PSUM_BW-1:0]     out_data;
  logic [IDX_BW-1:0]      out_idx;
  logic [COL-1:0]         overflow;
  logic                   round_done;
  logic                   busy;

  os_psum_collector dut (
    .clk        (clk),
    .reset      (reset),
    .os_ready   (os_ready),
    .os_output  (os_output),
    .relu_en    (relu_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .overflow   (overflow),
    .round_done (round_done),
    .busy       (busy)
  );

  int checks   = 0;
  int failures = 0;

  logic [PSUM_BW-1:0] tile_data [COL];

  int                 got_idx[$];
  logic [PSUM_BW-1:0] got_data[$];
  int                 rd_seen;

  // reference model: results captured but not yet accepted downstream
  bit                 pend_valid [COL];
  logic [PSUM_BW-1:0] pend_data  [COL];
  int                 acc_total;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    for (int i = 0; i < COL; i++) os_output[i*PSUM_BW +: PSUM_BW] = tile_data[i];
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    os_ready  = '0;
    out_ready = 1'b0;
    relu_en   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Record every accepted transfer until n have been seen or the budget runs out.
  task automatic collect(input int n, input int budget, input string tag);
    int cyc;
    cyc = 0;
    got_idx.delete();
    got_data.delete();
    rd_seen = 0;
    while (got_idx.size() < n && cyc < budget) begin
      if (out_valid && out_ready) begin
        got_idx.push_back(int'(out_idx));
        got_data.push_back(out_data);
      end
      tick();
      cyc++;
      if (round_done) rd_seen++;
    end
    check_eq({tag, " xfer_count"}, got_idx.size(), n);
    while (got_idx.size() < n) begin
      got_idx.push_back(-1);
      got_data.push_back('x);
    end
  endtask

  task automatic rnd_cycle(input bit allow_new);
    logic [COL-1:0]     prev;
    logic               pv, pr;
    int                 pi;
    logic [PSUM_BW-1:0] expd;
    bit                 exp_rd;
    bit                 any_pend;
    prev = os_ready;
    for (int i = 0; i < COL; i++) begin
      if (os_ready[i]) begin
        if ($urandom_range(2) == 0) os_ready[i] = 1'b0;
      end else if (allow_new && !pend_valid[i] && $urandom_range(3) == 0) begin
        tile_data[i] = PSUM_BW'($urandom);
        os_ready[i]  = 1'b1;
      end
    end
    out_ready = allow_new ? ($urandom_range(9) < 7) : 1'b1;
    pv = out_valid;
    pr = out_ready;
    pi = int'(out_idx);
    tick();
    exp_rd = 1'b0;
    if (pv && pr) begin
      check_eq("rnd pending_at_idx", pend_valid[pi], 1);
      expd = (relu_en && pend_data[pi][PSUM_BW-1]) ? '0 : pend_data[pi];
      check_eq("rnd out_data", got_data_of(pi, pv), expd);
      pend_valid[pi] = 1'b0;
      acc_total++;
      exp_rd = (acc_total % COL) == 0;
    end
    for (int i = 0; i < COL; i++) begin
      if (os_ready[i] && !prev[i]) begin
        pend_valid[i] = 1'b1;
        pend_data[i]  = tile_data[i];
      end
    end
    any_pend = 1'b0;
    for (int i = 0; i < COL; i++) any_pend |= pend_valid[i];
    check_eq("rnd round_done", round_done, exp_rd);
    check_eq("rnd busy", busy, any_pend);
    check_eq("rnd overflow", overflow, 0);
  endtask

  // Data presented on the edge where the accept happened (sampled before the edge).
  logic [PSUM_BW-1:0] last_pre_data;
  function automatic logic [PSUM_BW-1:0] got_data_of(input int idx, input logic v);
    return (v && idx >= 0) ? last_pre_data : '0;
  endfunction
  always @(negedge clk) last_pre_data = out_data;

  initial begin
    int n;
    for (int i = 0; i < COL; i++) tile_data[i] = '0;
    os_output = '0;

    // reset state
    do_reset();
    check_eq("reset out_valid", out_valid, 0);
    check_eq("reset out_data", out_data, 0);
    check_eq("reset out_idx", out_idx, 0);
    check_eq("reset overflow", overflow, 0);
    check_eq("reset round_done", round_done, 0);
    check_eq("reset busy", busy, 0);

    // single result, two-cycle latency
    out_ready    = 1'b1;
    tile_data[2] = 16'h0012;
    os_ready[2]  = 1'b1;
    tick();
    check_eq("single e0 out_valid", out_valid, 0);
    check_eq("single e0 busy", busy, 1);
    os_ready[2] = 1'b0;
    tick();
    check_eq("single e1 out_valid", out_valid, 1);
    check_eq("single e1 out_idx", out_idx, 2);
    check_eq("single e1 out_data", out_data, 16'h0012);
    tick();
    check_eq("single e2 out_valid", out_valid, 0);
    check_eq("single e2 busy", busy, 0);

    // held level produces one capture
    do_reset();
    out_ready    = 1'b1;
    tile_data[5] = 16'h0007;
    os_ready[5]  = 1'b1;
    n = 0;
    for (int c = 0; c < 14; c++) begin
      if (c == 10) os_ready[5] = 1'b0;
      if (out_valid && out_ready) begin
        n++;
        check_eq("held idx", out_idx, 5);
        check_eq("held data", out_data, 16'h0007);
      end
      tick();
    end
    check_eq("held transfers", n, 1);
    os_ready[5] = 1'b1;
    collect(1, 8, "held re-raise");
    check_eq("held re-raise idx", got_idx[0], 5);
    os_ready[5] = 1'b0;

    // simultaneous burst with backpressure
    do_reset();
    for (int i = 0; i < COL; i++) tile_data[i] = 16'h0100 + PSUM_BW'(i);
    os_ready = '1;
    tick();
    os_ready = '0;
    tick();
    check_eq("burst first out_valid", out_valid, 1);
    check_eq("burst first idx", out_idx, 0);
    check_eq("burst first data", out_data, 16'h0100);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("burst stall out_valid", out_valid, 1);
      check_eq("burst stall idx", out_idx, 0);
      check_eq("burst stall data", out_data, 16'h0100);
    end
    out_ready = 1'b1;
    collect(8, 12, "burst");
    for (int k = 0; k < COL; k++) begin
      check_eq("burst order idx", got_idx[k], k);
      check_eq("burst order data", got_data[k], 16'h0100 + PSUM_BW'(k));
    end
    check_eq("burst round_done pulses", rd_seen, 1);
    tick();
    check_eq("burst round_done clear", round_done, 0);
    check_eq("burst overflow", overflow, 0);
    check_eq("burst busy", busy, 0);

    // round-robin fairness
    do_reset();
    out_ready    = 1'b1;
    tile_data[3] = 16'h0033;
    os_ready[3]  = 1'b1;
    collect(1, 6, "rr first");
    check_eq("rr first idx", got_idx[0], 3);
    tile_data[1] = 16'h0011;
    tile_data[6] = 16'h0066;
    os_ready     = 8'h42;
    collect(2, 8, "rr pair");
    check_eq("rr pair first idx", got_idx[0], 6);
    check_eq("rr pair second idx", got_idx[1], 1);
    os_ready = '0;

    // overflow while the output stage is stalled
    do_reset();
    tile_data[7] = 16'h0077;
    os_ready[7]  = 1'b1;
    tick();
    tile_data[0] = 16'h0001;
    os_ready[0]  = 1'b1;
    tick();
    os_ready[0] = 1'b0;
    tick();
    check_eq("ovf before", overflow, 0);
    tile_data[0] = 16'h0002;
    os_ready[0]  = 1'b1;
    tick();
    check_eq("ovf set", overflow, 8'h01);
    os_ready = '0;
    tick();
    check_eq("ovf sticky", overflow, 8'h01);
    out_ready = 1'b1;
    collect(2, 6, "ovf drain");
    check_eq("ovf drain idx0", got_idx[0], 7);
    check_eq("ovf drain idx1", got_idx[1], 0);
    check_eq("ovf drain data1", got_data[1], 16'h0001);
    check_eq("ovf after drain", overflow, 8'h01);

    // same-edge drain and rise is not an overflow
    do_reset();
    tile_data[7] = 16'h0077;
    os_ready[7]  = 1'b1;
    tick();
    tile_data[0] = 16'h000A;
    os_ready[0]  = 1'b1;
    tick();
    os_ready[0] = 1'b0;
    tick();
    tile_data[0] = 16'h000B;
    os_ready[0]  = 1'b1;
    out_ready    = 1'b1;
    collect(3, 8, "same-edge");
    check_eq("same-edge idx0", got_idx[0], 7);
    check_eq("same-edge data1", got_data[1], 16'h000A);
    check_eq("same-edge data2", got_data[2], 16'h000B);
    check_eq("same-edge overflow", overflow, 0);
    os_ready = '0;

    // ReLU at output load
    do_reset();
    relu_en      = 1'b1;
    out_ready    = 1'b1;
    tile_data[4] = 16'hFFF0;
    tile_data[3] = 16'h7FF0;
    os_ready     = 8'h18;
    collect(2, 8, "relu");
    check_eq("relu idx0", got_idx[0], 3);
    check_eq("relu data0", got_data[0], 16'h7FF0);
    check_eq("relu idx1", got_idx[1], 4);
    check_eq("relu data1", got_data[1], 16'h0000);
    os_ready = '0;
    relu_en  = 1'b0;

    // reset while entries are held
    do_reset();
    tile_data[1] = 16'h0101;
    tile_data[2] = 16'h0202;
    tile_data[5] = 16'h0505;
    os_ready     = 8'h26;
    tick();
    tick();
    check_eq("midrst busy before", busy, 1);
    check_eq("midrst out_valid before", out_valid, 1);
    reset    = 1'b1;
    os_ready = '0;
    tick();
    reset = 1'b0;
    check_eq("midrst out_valid", out_valid, 0);
    check_eq("midrst out_data", out_data, 0);
    check_eq("midrst out_idx", out_idx, 0);
    check_eq("midrst busy", busy, 0);
    check_eq("midrst overflow", overflow, 0);
    check_eq("midrst round_done", round_done, 0);
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid) n++;
    end
    check_eq("midrst no out_valid after", n, 0);

    // randomized traffic against the transaction-level model, without and with ReLU
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      relu_en   = pass[0];
      acc_total = 0;
      for (int i = 0; i < COL; i++) pend_valid[i] = 1'b0;
      for (int c = 0; c < 600; c++) rnd_cycle(1'b1);
      for (int c = 0; c < 40; c++) rnd_cycle(1'b0);
      check_eq("rnd drained busy", busy, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
